// File: rtl/decryptor_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : aes_pkg
//  Description : Shared AES-128 definitions for the decryptor. Contains the
//                forward/inverse S-boxes, the round constants, GF(2^8) helpers,
//                inverse round transforms, key-schedule word helpers and the
//                controller state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

   typedef enum logic [1:0] {
      EXPAND = 2'd0,
      ADDKEY = 2'd1,
      ROUND  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Direction of one key-schedule step.
   typedef enum logic {
      KEY_FWD = 1'b0,
      KEY_INV = 1'b1
   } key_dir_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Round constant lookup that yields zero outside 1..10, so idle states
   // never index past the table.
   function automatic logic [7:0] rcon_at(input logic [3:0] idx);
      return (idx >= 4'd1 && idx <= 4'd10) ? RCON[idx] : 8'h00;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Byte k of a block lives at bits [127-8k -: 8]; byte 4c+r is row r, column c.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] blk);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = blk[127-8*(4*((c-r)&3)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] blk);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[8*i +: 8] = INV_SBOX[blk[8*i +: 8]];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] blk);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = blk[127-32*c    -: 8];
         a1 = blk[127-32*c-8  -: 8];
         a2 = blk[127-32*c-16 -: 8];
         a3 = blk[127-32*c-24 -: 8];
         o[127-32*c    -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
         o[127-32*c-8  -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
         o[127-32*c-16 -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
         o[127-32*c-24 -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
      end
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/decryptor_if.sv
`default_nettype none
// ============================================================================
//  Interface   : decryptor_if
//  Description : Data bus of the AES-128 decryptor.
//                ciphertext [127:0] block to decrypt (sampled while rst=1)
//                key        [127:0] cipher key (sampled while rst=1)
//                plaintext  [127:0] decrypted block, valid with done
//                done               plaintext valid, held until next rst
//                With DECRYPTOR_ROUND_OUT_EN defined also:
//                round_state[127:0] working state register
//                round_idx  [3:0]   10 in ADDKEY, round in ROUND, else 0
//                master = block driver, slave = decryptor.
//  Revision    : 1.0  initial release
// ============================================================================
interface decryptor_if;
   logic [127:0] ciphertext;
   logic [127:0] key;
   logic [127:0] plaintext;
   logic         done;
`ifdef DECRYPTOR_ROUND_OUT_EN
   logic [127:0] round_state;
   logic [3:0]   round_idx;

   modport master (output ciphertext, key, input plaintext, done, round_state, round_idx);
   modport slave  (input ciphertext, key, output plaintext, done, round_state, round_idx);
`else
   modport master (output ciphertext, key, input plaintext, done);
   modport slave  (input ciphertext, key, output plaintext, done);
`endif
endinterface
`default_nettype wire

// File: rtl/decryptor_key_step.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_step
//  Description : One AES-128 key-schedule step, purely combinational.
//                dir    KEY_FWD: next round key, KEY_INV: previous round key
//                rcon   [7:0] round constant for the step
//                rk_in  [127:0] current round key
//                rk_out [127:0] stepped round key
//  Revision    : 1.0  initial release
// ============================================================================
module aes_key_step
   import aes_pkg::*;
(
   input  key_dir_t     dir,
   input  logic [7:0]   rcon,
   input  logic [127:0] rk_in,
   output logic [127:0] rk_out
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] f0, f1, f2, f3;
   logic [31:0] p0, p1, p2, p3;

   assign w0 = rk_in[127:96];
   assign w1 = rk_in[95:64];
   assign w2 = rk_in[63:32];
   assign w3 = rk_in[31:0];

   // Forward: each word chains off the freshly computed previous word.
   assign f0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;

   // Inverse: words 1..3 unchain first; word 0 then needs the recovered word 3.
   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;
   assign p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon, 24'h000000};

   assign rk_out = (dir == KEY_INV) ? {p0, p1, p2, p3} : {f0, f1, f2, f3};

endmodule
`default_nettype wire

// File: rtl/decryptor.sv
`default_nettype none
// ============================================================================
//  Module      : decryptor
//  Description : Iterative AES-128 block decryptor, one round per clock.
//                Expands the key forward to round key 10 (10 cycles), adds it
//                (1 cycle), then runs 10 inverse rounds while stepping the key
//                schedule backwards on the fly. done rises 21 edges after rst.
//                clk  rising-edge clock
//                rst  synchronous active-high reset and load strobe
//                bus  decryptor_if.slave (ciphertext, key, plaintext, done)
//                Optional: DECRYPTOR_ROUND_OUT_EN exposes round_state/round_idx.
//  Revision    : 1.0  initial release
// ============================================================================
module decryptor
   import aes_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   decryptor_if.slave  bus
);

   state_t       state, state_nx;
   logic [3:0]   cnt, cnt_nx;
   logic [3:0]   round, round_nx;
   logic [127:0] ct_reg;
   logic [127:0] rk, rk_nx;
   logic [127:0] s, s_nx;
   logic [127:0] pt_reg, pt_nx;
   logic         done_reg, done_nx;

   key_dir_t     key_dir;
   logic [3:0]   rcon_idx;
   logic [7:0]   rcon_val;
   logic [127:0] rk_step;
   logic [127:0] t;

   // A single key-step unit serves both phases: forward during EXPAND,
   // inverse during ROUND (round r undoes the step that used rcon[r+1]).
   assign key_dir  = (state == ROUND) ? KEY_INV : KEY_FWD;
   assign rcon_idx = (state == ROUND) ? (round + 4'd1) : cnt;
   assign rcon_val = rcon_at(rcon_idx);

   aes_key_step u_key_step (
      .dir    (key_dir),
      .rcon   (rcon_val),
      .rk_in  (rk),
      .rk_out (rk_step)
   );

   assign t = inv_sub_bytes(inv_shift_rows(s)) ^ rk_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EXPAND;
         cnt      <= 4'd1;
         round    <= 4'd0;
         ct_reg   <= bus.ciphertext;
         rk       <= bus.key;
         s        <= '0;
         pt_reg   <= '0;
         done_reg <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         round    <= round_nx;
         rk       <= rk_nx;
         s        <= s_nx;
         pt_reg   <= pt_nx;
         done_reg <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      round_nx = round;
      rk_nx    = rk;
      s_nx     = s;
      pt_nx    = pt_reg;
      done_nx  = done_reg;
      case (state)
         EXPAND: begin
            rk_nx = rk_step;
            if (cnt == 4'd10) state_nx = ADDKEY;
            else              cnt_nx   = cnt + 4'd1;
         end
         ADDKEY: begin
            s_nx     = ct_reg ^ rk;
            round_nx = 4'd9;
            state_nx = ROUND;
         end
         ROUND: begin
            rk_nx = rk_step;
            if (round == 4'd0) begin
               // Final round has no InvMixColumns.
               s_nx     = t;
               pt_nx    = t;
               done_nx  = 1'b1;
               state_nx = DONE;
            end else begin
               s_nx     = inv_mix_columns(t);
               round_nx = round - 4'd1;
            end
         end
         default: ;
      endcase
   end

   assign bus.plaintext = pt_reg;
   assign bus.done      = done_reg;

`ifdef DECRYPTOR_ROUND_OUT_EN
   assign bus.round_state = s;
   assign bus.round_idx   = (state == ADDKEY) ? 4'd10 :
                            (state == ROUND)  ? round : 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decryptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decryptor
//  Description : Self-checking bench for decryptor. Reference is a
//                byte-level AES-128 model whose S-box is derived from the
//                GF(2^8) inverse plus affine map.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decryptor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decryptor_if bus ();

   decryptor u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   // ---------------- reference model ----------------
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return 8'((v << n) | (v >> (8 - n)));
   endfunction

   function automatic void build_tables();
      logic [7:0] inv, y;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int z = 1; z < 256; z++)
            if (gm(8'(x), 8'(z)) == 8'h01) inv = 8'(z);
         y = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
         sb[x]  = y;
         isb[y] = 8'(x);
      end
   endfunction

   function automatic logic [127:0] model_rk(input logic [127:0] k, input int n);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endfunction

   function automatic logic [127:0] f_sub(input logic [127:0] x, input bit inv);
      logic [127:0] y = '0;
      for (int i = 0; i < 16; i++)
         y[127-8*i -: 8] = inv ? isb[x[127-8*i -: 8]] : sb[x[127-8*i -: 8]];
      return y;
   endfunction

   function automatic logic [127:0] f_shift(input logic [127:0] x, input bit inv);
      logic [127:0] y = '0;
      int src;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c - r + 4) % 4 : (c + r) % 4;
            y[127-8*(4*c+r) -: 8] = x[127-8*(4*src+r) -: 8];
         end
      return y;
   endfunction

   function automatic logic [127:0] f_mix(input logic [127:0] x, input bit inv);
      logic [127:0] y = '0;
      logic [7:0]   cf [4];
      logic [7:0]   acc;
      if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
      else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc ^= gm(cf[(k - r + 4) % 4], x[127-8*(4*c+k) -: 8]);
            y[127-8*(4*c+r) -: 8] = acc;
         end
      return y;
   endfunction

   function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k);
      logic [127:0] st = pt ^ model_rk(k, 0);
      for (int rnd = 1; rnd < 10; rnd++)
         st = f_mix(f_shift(f_sub(st, 0), 0), 0) ^ model_rk(k, rnd);
      return f_shift(f_sub(st, 0), 0) ^ model_rk(k, 10);
   endfunction

   function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] k);
      logic [127:0] st = ct ^ model_rk(k, 10);
      for (int rnd = 9; rnd >= 1; rnd--)
         st = f_mix(f_sub(f_shift(st, 1), 1) ^ model_rk(k, rnd), 1);
      return f_sub(f_shift(st, 1), 1) ^ model_rk(k, 0);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load via rst (optionally preceded by extra rst cycles with junk inputs,
   // which must be overwritten), then wait for done and check everything.
   task automatic run_block(input string name, input logic [127:0] k,
                            input logic [127:0] ct, input logic [127:0] exp_pt,
                            input int extra_rst);
      int lat;
      int early_ok;
      for (int i = 0; i < extra_rst; i++) begin
         rst = 1'b1; bus.key = rand128(); bus.ciphertext = rand128();
         step();
      end
      rst = 1'b1; bus.key = k; bus.ciphertext = ct;
      step();
      chk_int({name, " rst done"}, int'(bus.done), 0);
      chk128({name, " rst plaintext"}, bus.plaintext, '0);
      rst = 1'b0;
      lat = 0;
      early_ok = 1;
      while (lat < 40) begin
         step();
         lat++;
         if (bus.done) break;
         if (bus.plaintext !== '0) early_ok = 0;
      end
      chk_int({name, " latency"}, lat, 21);
      chk_int({name, " early outputs zero"}, early_ok, 1);
      chk128({name, " plaintext"}, bus.plaintext, exp_pt);
   endtask

   typedef struct {
      string        name;
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   vec_t vecs [3];

   initial begin
      int           lat;
      int           ok;
      logic [127:0] k, p;

      bus.key = '0;
      bus.ciphertext = '0;
      build_tables();

      vecs[0] = '{"c1",   128'h000102030405060708090a0b0c0d0e0f,
                          128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                          128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{"appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                          128'h3925841d02dc09fbdc118597196a0b32,
                          128'h3243f6a8885a308d313198a2e0370734};
      vecs[2] = '{"demo", 128'h6d65677361797372617772746f796f75,
                          128'h7d98af48b3c1e41cc809736f9ccf67c3, '0};
      vecs[2].pt = model_dec(vecs[2].ct, vecs[2].key);

      // Fixed vectors from the table
      for (int i = 0; i < 3; i++)
         run_block(vecs[i].name, vecs[i].key, vecs[i].ct, vecs[i].pt, 0);
      chk128("demo reencrypt", model_enc(bus.plaintext, vecs[2].key), vecs[2].ct);

      // Reset mid-run: abort at edge 12 with vector 1 inputs loaded
      rst = 1'b1; bus.key = vecs[0].key; bus.ciphertext = vecs[0].ct;
      step();
      rst = 1'b0;
      for (int i = 0; i < 11; i++) step();
      rst = 1'b1; bus.key = vecs[1].key; bus.ciphertext = vecs[1].ct;
      step();
      chk_int("abort done", int'(bus.done), 0);
      rst = 1'b0;
      lat = 0;
      while (lat < 40) begin step(); lat++; if (bus.done) break; end
      chk_int("abort latency", lat, 21);
      chk128("abort plaintext", bus.plaintext, vecs[1].pt);

      // Inputs toggling while rst=0 must be ignored; outputs then hold
      rst = 1'b1; bus.key = vecs[0].key; bus.ciphertext = vecs[0].ct;
      step();
      rst = 1'b0;
      lat = 0;
      while (lat < 40) begin
         bus.key = rand128(); bus.ciphertext = rand128();
         step(); lat++;
         if (bus.done) break;
      end
      chk_int("toggle latency", lat, 21);
      chk128("toggle plaintext", bus.plaintext, vecs[0].pt);
      ok = 1;
      for (int i = 0; i < 50; i++) begin
         bus.key = rand128(); bus.ciphertext = rand128();
         step();
         if (bus.done !== 1'b1 || bus.plaintext !== vecs[0].pt) ok = 0;
      end
      chk_int("hold stable", ok, 1);

      // All-zero key and ciphertext
      run_block("zeros", '0, '0, model_dec('0, '0), 0);

      // Random back-to-back blocks, encrypted by the model
      for (int i = 0; i < 100; i++) begin
         k = rand128();
         p = rand128();
         run_block($sformatf("rand%0d", i), k, model_enc(p, k), p, int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decryptor.md
Name: decryptor

Overview:
AES-128 (FIPS-197) block decryptor: one 128-bit ciphertext block and 128-bit key in, 128-bit plaintext out. Iterative, one round per clock. Forward key expansion runs first to reach round key 10. The inverse key schedule is then applied on the fly during decryption. Sits downstream of the encryptor and recovers the original message block for display or readback.

Parameters:
none (AES-128 fixed: Nk=4, Nr=10)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset; also the load/start strobe
ciphertext  input  128  block to decrypt, sampled while rst=1
key  input  128  cipher key, sampled while rst=1
plaintext  output  128  decrypted block, valid when done=1
done  output  1  high when plaintext is valid; held until next rst

Behaviour:
- Byte order: bits [127:120] are byte 0, the first FIPS-197 byte. State is column-major: bytes 0-3 form column 0. The same order applies to key and plaintext.
- Reset (rst=1 at a clock edge):
  - ct_reg <= ciphertext; rk <= key; plaintext <= 0; done <= 0; state <= EXPAND; cnt <= 1.
  - Every clock edge with rst=1 re-samples the inputs.
- Inputs are ignored whenever rst=0. Changing them mid-operation has no effect.
- EXPAND (10 cycles, cnt 1..10):
  - rk <= next_rk(rk, rcon[cnt]), using RotWord, SubWord and rcon 01,02,04,08,10,20,40,80,1b,36.
  - After cnt=10, rk holds round key 10 -> go to ADDKEY.
- ADDKEY (1 cycle): s <= ct_reg ^ rk; round <= 9 -> go to ROUND.
- ROUND (10 cycles, round 9..0):
  - rk_prev = inverse key schedule of rk using rcon[round+1]: w[i] = w[i+4] ^ w[i+3] for words 1..3; word 0 = w4 ^ SubWord(RotWord(w3)) ^ rcon.
  - t = InvSubBytes(InvShiftRows(s)) ^ rk_prev.
  - s <= (round != 0) ? InvMixColumns(t) : t; rk <= rk_prev.
  - When round=0: plaintext <= t; done <= 1 -> go to DONE. Otherwise round <= round-1.
- DONE: plaintext and done hold until rst.
- Latency: done first reads 1 after the 21st rising edge following rst deassertion (10 EXPAND + 1 ADDKEY + 10 ROUND).
- Reset mid-operation aborts immediately and restarts from EXPAND with freshly sampled inputs. done drops on that same edge.
- All-zero key and all-zero ciphertext are legal; there are no error conditions.
- Arithmetic:
  - GF(2^8) with polynomial 0x11b; xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0).
  - InvMixColumns coefficients: 0e, 0b, 0d, 09.
- S-box and inverse S-box are 256-entry constant lookup functions. Only combinational logic sits between the state registers.

Optional Feature:
DECRYPTOR_ROUND_OUT_EN
- Defined: adds output round_state [127:0] (= s register) and output round_idx [3:0], which reads 10 in ADDKEY, the current round during ROUND, and 0 in DONE and EXPAND. Both reset to 0.
- Undefined: these ports and their logic are absent. Core timing and values are identical either way.

Decomposition:
- Package aes_pkg:
  - SBOX and INV_SBOX as functions or localparam arrays.
  - RCON[1:10].
  - Functions: xtime, gmul, inv_shift_rows, inv_sub_bytes, inv_mix_columns, sub_word, rot_word.
  - State enum: EXPAND, ADDKEY, ROUND, DONE.
- One natural sub-module, aes_key_step: combinational, with a mode input selecting forward next_rk vs inverse prev_rk for a given rcon.
- Everything else is in decryptor.

Test Plan:
1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, one-cycle rst -> done=1 exactly at edge 21, plaintext 00112233445566778899aabbccddeeff.
2. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734; done=0 and plaintext=0 on every earlier cycle.
3. Demo vector: key 6d65677361797372617772746f796f75, ciphertext 7d98af48b3c1e41cc809736f9ccf67c3 -> plaintext equals a software AES-128 reference decrypt. Re-encrypting that plaintext with the encryptor returns the ciphertext.
4. Reset mid-run: apply vector 1, assert rst at edge 12 with vector 2 inputs -> done=0 at that edge; vector 2 result appears 21 edges after the release.
5. Input changes after release: toggle ciphertext and key randomly during the run -> result unchanged from vector 1. Result and done hold stable for 50 cycles after done.
6. Back-to-back: 100 random key/plaintext pairs, each encrypted by a software model, each started with rst -> every plaintext matches, and latency is 21 every time.
